// File: rtl/cpu_mem_arbiter.sv
// cpu_mem_arbiter: shares one registered memory bus between an instruction-fetch port and a data port.
// Optional macro ARB_ROUND_ROBIN_EN alternates grants under contention; by default data wins.
module cpu_mem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              i_addr_ok,
  output logic              i_data_ok,
  output logic [DATA_W-1:0] i_rdata,
  input  logic              d_req,
  input  logic              d_wr,
  input  logic [1:0]        d_size,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [DATA_W-1:0] d_wdata,
  output logic              d_addr_ok,
  output logic              d_data_ok,
  output logic [DATA_W-1:0] d_rdata,
  output logic              m_req,
  output logic              m_wr,
  output logic [1:0]        m_size,
  output logic [ADDR_W-1:0] m_addr,
  output logic [DATA_W-1:0] m_wdata,
  input  logic              m_addr_ok,
  input  logic              m_data_ok,
  input  logic [DATA_W-1:0] m_rdata
);

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA} state_t;

  state_t              r_state;
  state_t              w_next_state;
  logic                r_last_grant;
  logic                r_m_req;
  logic                r_m_wr;
  logic [1:0]          r_m_size;
  logic [ADDR_W-1:0]   r_m_addr;
  logic [DATA_W-1:0]   r_m_wdata;
  logic                w_owner;
  logic                w_any_req;
  logic                w_grant;
  logic                w_grant_data;
  logic                w_addr_acc;
  logic                w_data_done;

  // Owner and last grant are both loaded with the winner at every grant, so one flop serves both.
  assign w_owner   = r_last_grant;
  assign w_any_req = i_req | d_req;
  assign w_grant   = (r_state == S_IDLE) & w_any_req;

`ifdef ARB_ROUND_ROBIN_EN
  assign w_grant_data = d_req & (~i_req | ~r_last_grant);
`else
  assign w_grant_data = d_req;
`endif

  always_comb begin
    // NOTE: every signal written here gets a default first, so no path can infer a latch.
    w_next_state = r_state;
    w_addr_acc   = 1'b0;
    w_data_done  = 1'b0;
    case (r_state)
      S_IDLE: if (w_any_req) w_next_state = S_ADDR;
      S_ADDR: if (m_addr_ok) begin
        w_addr_acc   = 1'b1;
        w_next_state = S_DATA;
      end
      S_DATA: if (m_data_ok) begin
        w_data_done  = 1'b1;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so all flops sample pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next_state;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last_grant <= 1'b0;
      r_m_req      <= 1'b0;
      r_m_wr       <= 1'b0;
      r_m_size     <= 2'd0;
      r_m_addr     <= '0;
      r_m_wdata    <= '0;
    end else begin
      r_m_req <= (w_next_state == S_ADDR);
      if (w_grant) begin
        r_last_grant <= w_grant_data;
        if (w_grant_data) begin
          r_m_wr    <= d_wr;
          r_m_size  <= d_size;
          r_m_addr  <= d_addr;
          r_m_wdata <= d_wdata;
        end else begin
          r_m_wr    <= 1'b0;
          r_m_size  <= 2'd2;
          r_m_addr  <= i_addr;
          r_m_wdata <= '0;
        end
      end
    end
  end

  assign m_req   = r_m_req;
  assign m_wr    = r_m_wr;
  assign m_size  = r_m_size;
  assign m_addr  = r_m_addr;
  assign m_wdata = r_m_wdata;

  assign i_addr_ok = w_addr_acc  & ~w_owner;
  assign d_addr_ok = w_addr_acc  &  w_owner;
  assign i_data_ok = w_data_done & ~w_owner;
  assign d_data_ok = w_data_done &  w_owner;
  assign i_rdata   = m_rdata;
  assign d_rdata   = m_rdata;

endmodule

// File: tb/tb_cpu_mem_arbiter.sv
// Self-checking bench for cpu_mem_arbiter: directed scenarios plus randomized transactions
// checked against a transaction-level model of the arbitration rules.
module tb_cpu_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        i_req, i_addr_ok, i_data_ok;
  logic [31:0] i_addr, i_rdata;
  logic        d_req, d_wr, d_addr_ok, d_data_ok;
  logic [1:0]  d_size;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic        m_req, m_wr, m_addr_ok, m_data_ok;
  logic [1:0]  m_size;
  logic [31:0] m_addr, m_wdata, m_rdata;

  int   n_cmp = 0;
  int   n_bad = 0;
  logic model_last = 1'b0;  // 0 = fetch won last, 1 = data won last

  always #5 clk = ~clk;

  cpu_mem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst(rst),
    .i_req(i_req), .i_addr(i_addr), .i_addr_ok(i_addr_ok), .i_data_ok(i_data_ok), .i_rdata(i_rdata),
    .d_req(d_req), .d_wr(d_wr), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_addr_ok(d_addr_ok), .d_data_ok(d_data_ok), .d_rdata(d_rdata),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata)
  );

  function automatic logic [67:0] bus_obs();
    return {m_req, m_wr, m_size, m_addr, m_wdata};
  endfunction

  function automatic logic [3:0] ok_obs();
    return {i_addr_ok, i_data_ok, d_addr_ok, d_data_ok};
  endfunction

  // Winner of one arbitration: 1 = data, 0 = fetch.
  function automatic logic model_pick(input logic ir, input logic dr);
    if (ir && dr) begin
`ifdef ARB_ROUND_ROBIN_EN
      return ~model_last;
`else
      return 1'b1;
`endif
    end
    return dr;
  endfunction

  task automatic randomize_fields();
    i_addr  = $urandom;
    d_addr  = $urandom;
    d_wdata = $urandom;
    d_wr    = 1'($urandom_range(0, 1));
    d_size  = 2'($urandom_range(0, 2));
  endtask

  // One complete transaction: IDLE sample cycle, alat stall cycles plus the accept cycle,
  // dlat wait cycles plus the completion cycle.
  task automatic run_txn(input string tag, input logic ir, input logic dr,
                         input logic [31:0] ia, input logic [31:0] da, input logic [31:0] dwd,
                         input logic dwr, input logic [1:0] dsz,
                         input int alat, input int dlat, input logic [31:0] rd, input logic drop);
    logic        own;
    logic [67:0] exp_bus;
    logic [3:0]  exp_ok;
    own        = model_pick(ir, dr);
    model_last = own;
    exp_bus    = own ? {1'b1, dwr, dsz, da, dwd} : {1'b1, 1'b0, 2'd2, ia, 32'h0};

    i_req = ir; d_req = dr; i_addr = ia; d_addr = da; d_wdata = dwd; d_wr = dwr; d_size = dsz;
    m_addr_ok = 1'($urandom_range(0, 1));
    m_data_ok = 1'($urandom_range(0, 1));
    m_rdata   = $urandom;
    @(negedge clk);
    n_cmp++;
    if ({m_req, ok_obs()} !== 5'b0) begin
      n_bad++;
      $display("FAIL %s idle: m_req/ok got %b expected 00000", tag, {m_req, ok_obs()});
    end
    @(posedge clk); #1;

    if (drop) begin
      i_req = 1'b0; d_req = 1'b0;
      randomize_fields();
    end
    for (int k = 0; k <= alat; k++) begin
      m_addr_ok = (k == alat);
      m_data_ok = 1'($urandom_range(0, 1));
      exp_ok    = (k == alat) ? (own ? 4'b0010 : 4'b1000) : 4'b0000;
      @(negedge clk);
      n_cmp++;
      if (bus_obs() !== exp_bus) begin
        n_bad++;
        $display("FAIL %s addr_bus[%0d]: got %h expected %h", tag, k, bus_obs(), exp_bus);
      end
      n_cmp++;
      if (ok_obs() !== exp_ok) begin
        n_bad++;
        $display("FAIL %s addr_ok[%0d]: got %b expected %b", tag, k, ok_obs(), exp_ok);
      end
      @(posedge clk); #1;
    end

    for (int k = 0; k <= dlat; k++) begin
      m_data_ok = (k == dlat);
      m_addr_ok = 1'($urandom_range(0, 1));
      m_rdata   = (k == dlat) ? rd : $urandom;
      exp_ok    = (k == dlat) ? (own ? 4'b0001 : 4'b0100) : 4'b0000;
      @(negedge clk);
      n_cmp++;
      if ({m_req, ok_obs()} !== {1'b0, exp_ok}) begin
        n_bad++;
        $display("FAIL %s data_ok[%0d]: m_req/ok got %b expected %b", tag, k, {m_req, ok_obs()}, {1'b0, exp_ok});
      end
      if (k == dlat) begin
        n_cmp++;
        if ((own ? d_rdata : i_rdata) !== rd) begin
          n_bad++;
          $display("FAIL %s rdata: got %h expected %h", tag, own ? d_rdata : i_rdata, rd);
        end
      end
      @(posedge clk); #1;
    end
    m_addr_ok = 1'b0;
    m_data_ok = 1'b0;
  endtask

  task automatic pulse_reset();
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    i_req = 1'b1; d_req = 1'b1; m_addr_ok = 1'b1; m_data_ok = 1'b1; m_rdata = $urandom;
    randomize_fields();
    repeat (2) @(negedge clk);
    n_cmp++;
    if (bus_obs() !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_bus: got %h expected %h", bus_obs(), 68'h0);
    end
    n_cmp++;
    if (ok_obs() !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_ok: got %b expected 0000", ok_obs());
    end
    @(posedge clk); #1;
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0;
    rst = 1'b0;
    model_last = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (bus_obs() !== 68'h0) begin
      n_bad++;
      $display("FAIL reset_release_bus: got %h expected %h", bus_obs(), 68'h0);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fetch_alone();
    run_txn("fetch_alone", 1'b1, 1'b0, 32'hBFC0_0000, 32'h0, 32'h0, 1'b0, 2'd0,
            1, 0, 32'h3C08_0001, 1'b0);
  endtask

  task automatic test_store_stall();
    run_txn("store_stall", 1'b0, 1'b1, 32'h1234_5678, 32'h8000_1003, 32'h0000_00AB, 1'b1, 2'd0,
            4, 2, 32'h5A5A_0000, 1'b0);
  endtask

  task automatic test_spurious();
    i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 4; k++) begin
      m_addr_ok = (k != 1);
      m_data_ok = (k != 2);
      @(negedge clk);
      n_cmp++;
      if ({m_req, ok_obs()} !== 5'b0) begin
        n_bad++;
        $display("FAIL spurious[%0d]: m_req/ok got %b expected 00000", k, {m_req, ok_obs()});
      end
      @(posedge clk); #1;
    end
    m_addr_ok = 1'b0; m_data_ok = 1'b0;
    run_txn("after_spurious", 1'b1, 1'b0, 32'h0000_0040, 32'h0, 32'h0, 1'b0, 2'd0,
            0, 0, 32'hCAFE_F00D, 1'b0);
  endtask

  task automatic test_simultaneous();
    pulse_reset();
    for (int t = 0; t < 4; t++)
      run_txn($sformatf("simul%0d", t), 1'b1, 1'b1, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)), 1, 1, $urandom, 1'b0);
  endtask

  task automatic test_reset_in_data();
    i_req = 1'b1; d_req = 1'b0; i_addr = 32'h0000_1000;
    @(posedge clk); #1;
    m_addr_ok = 1'b1;
    @(posedge clk); #1;
    m_addr_ok = 1'b0;
    rst = 1'b1;
    m_data_ok = 1'b1;
    #1;
    n_cmp++;
    if ({bus_obs(), ok_obs()} !== 72'h0) begin
      n_bad++;
      $display("FAIL reset_in_data: bus/ok got %h expected 0", {bus_obs(), ok_obs()});
    end
    i_req = 1'b0;
    m_data_ok = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_last = 1'b0;
    m_data_ok = 1'b1;
    @(negedge clk);
    n_cmp++;
    if ({m_req, ok_obs()} !== 5'b0) begin
      n_bad++;
      $display("FAIL stale_data_ok: m_req/ok got %b expected 00000", {m_req, ok_obs()});
    end
    @(posedge clk); #1;
    m_data_ok = 1'b0;
    run_txn("after_reset", 1'b1, 1'b1, 32'h0000_2000, 32'h0000_3000, 32'h1111_2222, 1'b1, 2'd1,
            0, 1, 32'h7777_8888, 1'b0);
  endtask

  task automatic test_random();
    logic ir, dr;
    for (int t = 0; t < 40; t++) begin
      int gap;
      gap = $urandom_range(0, 2);
      i_req = 1'b0; d_req = 1'b0;
      for (int g = 0; g < gap; g++) begin
        m_addr_ok = 1'($urandom_range(0, 1));
        m_data_ok = 1'($urandom_range(0, 1));
        @(negedge clk);
        n_cmp++;
        if ({m_req, ok_obs()} !== 5'b0) begin
          n_bad++;
          $display("FAIL rand_gap%0d: m_req/ok got %b expected 00000", t, {m_req, ok_obs()});
        end
        @(posedge clk); #1;
      end
      ir = 1'($urandom_range(0, 1));
      dr = ir ? 1'($urandom_range(0, 1)) : 1'b1;
      run_txn($sformatf("rand%0d", t), ir, dr, $urandom, $urandom, $urandom,
              1'($urandom_range(0, 1)), 2'($urandom_range(0, 2)),
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    i_req = 1'b0; d_req = 1'b0; m_addr_ok = 1'b0; m_data_ok = 1'b0; m_rdata = '0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_wr = 1'b0; d_size = 2'd0;
    test_reset();
    test_fetch_alone();
    test_store_stall();
    test_spurious();
    test_simultaneous();
    test_reset_in_data();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
